// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: the pipeline writeback always wins, and MUL/DIV results
// queue in a small FIFO. A pending-destination scoreboard drives the decode stall.
module regfile_wb_scheduler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIPE_WB_VALID,
  input  logic [4:0]  PIPE_WB_ADDR,
  input  logic [31:0] PIPE_WB_DATA,
  input  logic        MDU_VALID,
  input  logic [4:0]  MDU_ADDR,
  input  logic [31:0] MDU_DATA,
  output logic        MDU_READY,
  input  logic        ISSUE_MDU,
  input  logic [4:0]  ISSUE_RD,
  input  logic [4:0]  ADRS1,
  input  logic [4:0]  ADRS2,
  input  logic [4:0]  ADRS_RD,
  output logic        STALL_OUT,
  output logic [4:0]  WB_ADDRESS,
  output logic [31:0] WRITE_DATA,
  output logic        WRITE_ENABLE,
  output logic [31:0] BUSY_VEC,
  output logic [CNT_W-1:0] FIFO_COUNT,
  output logic        PROTO_ERR
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [4:0]       fifo_addr_q [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      busy_q, busy_d;
  logic             proto_err_q;

  logic pipe_req, fifo_empty, push, pop;

  assign pipe_req   = PIPE_WB_VALID && (PIPE_WB_ADDR != 5'd0);
  assign fifo_empty = (count_q == '0);
  // Readiness looks only at the registered count, so a full FIFO refuses a push even while it pops.
  assign MDU_READY  = RESET && (count_q < CNT_W'(DEPTH));
  assign push       = MDU_VALID && MDU_READY && (MDU_ADDR != 5'd0);
  assign pop        = !pipe_req && !fifo_empty;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    WRITE_ENABLE = 1'b0;
    WB_ADDRESS   = 5'd0;
    WRITE_DATA   = 32'd0;
    if (RESET && pipe_req) begin
      WRITE_ENABLE = 1'b1;
      WB_ADDRESS   = PIPE_WB_ADDR;
      WRITE_DATA   = PIPE_WB_DATA;
    end else if (pop) begin
      WRITE_ENABLE = 1'b1;
      WB_ADDRESS   = fifo_addr_q[rd_ptr_q];
      WRITE_DATA   = fifo_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[fifo_addr_q[rd_ptr_q]] = 1'b0;
    if (ISSUE_MDU && (ISSUE_RD != 5'd0)) busy_d[ISSUE_RD] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      busy_q  <= busy_d;
      if (pipe_req && busy_q[PIPE_WB_ADDR]) proto_err_q <= 1'b1;
    end
  end

  // NOTE: storage is left unreset; the count and pointers alone decide which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= MDU_ADDR;
      fifo_data_q[wr_ptr_q] <= MDU_DATA;
    end
  end

  assign STALL_OUT  = busy_q[ADRS1] | busy_q[ADRS2] | busy_q[ADRS_RD];
  assign BUSY_VEC   = busy_q;
  assign FIFO_COUNT = count_q;
  assign PROTO_ERR  = proto_err_q;

endmodule
